// File: rtl/voting_pkg.sv
// Shared ballot/tally definitions: candidate codes, ballot FSM states, button decode helpers.
package voting_pkg;

  localparam logic [2:0] CAND_NONE = 3'b000;
  localparam logic [2:0] CAND_1    = 3'b001;
  localparam logic [2:0] CAND_2    = 3'b010;
  localparam logic [2:0] CAND_3    = 3'b011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAST    = 2'd2,
    LOCKOUT = 2'd3
  } ballot_state_t;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Button bit position maps to candidate number; anything not one-hot is no vote.
  function automatic logic [2:0] cand_code(input logic [2:0] onehot);
    logic [2:0] code;
    code = CAND_NONE;
    case (onehot)
      3'b001:  code = CAND_1;
      3'b010:  code = CAND_2;
      3'b100:  code = CAND_3;
      default: code = CAND_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ballot_unit_if.sv
// Front-panel inputs and the candidate port towards the tally block, plus FSM state for observation.
interface ballot_unit_if;
  import voting_pkg::*;

  // candidate is a one-cycle valid strobe: nonzero means one vote, there is no
  // backpressure. ready is the voter lamp (ballot armed), not a flow-control signal.
  logic          arm;
  logic [2:0]    btn;
  logic [2:0]    candidate;
  logic          ready;
  logic          busy;
  logic          timeout;
  ballot_state_t state;
`ifdef BALLOT_AUDIT_EN
  logic [15:0]   ballots_cast;
  logic [15:0]   ballots_void;

  modport master (
    input  arm, btn,
    output candidate, ready, busy, timeout, state, ballots_cast, ballots_void
  );
  modport slave (
    output arm, btn,
    input  candidate, ready, busy, timeout, state, ballots_cast, ballots_void
  );
`else
  modport master (
    input  arm, btn,
    output candidate, ready, busy, timeout, state
  );
  modport slave (
    output arm, btn,
    input  candidate, ready, busy, timeout, state
  );
`endif

endinterface

// File: rtl/btn_debounce.sv
// Two-flop button synchronizer plus a stability counter; stable only for a held one-hot pattern.
module btn_debounce
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn,
  output logic [2:0] sbtn,
  output logic       stable
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [CW-1:0] cnt;

  // The count restarts on the edge where the synchronized value changes, so it
  // reaches CNT_MAX after DEBOUNCE_CYCLES further samples of the same pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign sbtn   = sync2;
  assign stable = (cnt == CNT_MAX) && is_onehot(sync2);

endmodule

// File: rtl/ballot_unit.sv
// Voter-side ballot entry: arm, debounced single press, one candidate strobe, lockout, timeout.
// Define BALLOT_AUDIT_EN to add saturating ballots_cast / ballots_void counters.
module ballot_unit
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  ballot_unit_if.master cand_if
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            LW       = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LK_LAST  = LW'(LOCKOUT_CYCLES - 1);

  ballot_state_t state;
  ballot_state_t next_state;
  logic [2:0]    sbtn;
  logic          stable;
  logic [TW-1:0] tmo_cnt;
  logic [LW-1:0] lk_cnt;
  logic          tmo_fire;
  logic          cast_fire;
  logic [2:0]    candidate_q;
  logic          ready_q;
  logic          busy_q;
  logic          timeout_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (cand_if.btn),
    .sbtn   (sbtn),
    .stable (stable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A stable press and timeout expiry in the same cycle resolve to a cast.
  always_comb begin
    next_state = state;
    tmo_fire   = 1'b0;
    cast_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (cand_if.arm) next_state = ARMED;
      end
      ARMED: begin
        if (stable) begin
          next_state = CAST;
          cast_fire  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = IDLE;
          tmo_fire   = 1'b1;
        end
      end
      CAST: begin
        next_state = LOCKOUT;
      end
      LOCKOUT: begin
        if ((lk_cnt == LK_LAST) && (sbtn == 3'b000)) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Both timers sit at zero outside their state, which gives the clear-on-entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      lk_cnt  <= '0;
    end else begin
      if (state != ARMED) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (state != LOCKOUT) begin
        lk_cnt <= '0;
      end else if (lk_cnt != LK_LAST) begin
        lk_cnt <= lk_cnt + LW'(1);
      end
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate_q <= CAND_NONE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      candidate_q <= cast_fire ? cand_code(sbtn) : CAND_NONE;
      ready_q     <= (next_state == ARMED);
      busy_q      <= (next_state == CAST) || (next_state == LOCKOUT);
      timeout_q   <= tmo_fire;
    end
  end

  assign cand_if.candidate = candidate_q;
  assign cand_if.ready     = ready_q;
  assign cand_if.busy      = busy_q;
  assign cand_if.timeout   = timeout_q;
  assign cand_if.state     = state;

`ifdef BALLOT_AUDIT_EN
  logic [15:0] cast_cnt;
  logic [15:0] void_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cast_cnt <= '0;
      void_cnt <= '0;
    end else begin
      if (cast_fire && (cast_cnt != 16'hFFFF)) cast_cnt <= cast_cnt + 16'd1;
      if (tmo_fire && (void_cnt != 16'hFFFF))  void_cnt <= void_cnt + 16'd1;
    end
  end

  assign cand_if.ballots_cast = cast_cnt;
  assign cand_if.ballots_void = void_cnt;
`endif

endmodule

// File: doc/ballot_unit.md
# ballot_unit

Voter-side ballot entry unit: the transmitting end of the `candidate` interface consumed by the vote-tallying machine. It accepts a presiding-officer arm pulse, debounces three raw candidate buttons, and emits exactly one valid candidate code per armed ballot. It enforces one vote per arming, rejects multi-button presses, and times out unused ballots. It sits between the front-panel inputs and the tally block's `candidate` port, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized cycles a single-button pattern must hold before it is accepted (≥1).
- `LOCKOUT_CYCLES`, 8: minimum cycles spent in LOCKOUT after a cast (≥1).
- `TIMEOUT_CYCLES`, 64: cycles ARMED may persist without a valid press before the ballot is voided (≥1).
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  presiding-officer enable pulse, synchronous to `clk`.
- `btn`  in  3  raw asynchronous buttons; bit0 = cand 1, bit1 = cand 2, bit2 = cand 3.
- `candidate`  out  3  code to tally: 3'b001/3'b010/3'b011 for one cycle on cast, else 3'b000.
- `ready`  out  1  high while ARMED (voter lamp).
- `busy`  out  1  high in CAST and LOCKOUT.
- `timeout`  out  1  one-cycle pulse when an armed ballot expires unused.

## Operation
- `btn` passes through a 2-flop synchronizer per bit; all decisions use the synchronized value `sbtn`.
- Debounce: a counter tracks how long `sbtn` has been unchanged. `stable` means `sbtn` is one-hot and has held for DEBOUNCE_CYCLES samples. Zero or multi-hot patterns never become stable; any change clears the count.
- FSM states: IDLE, ARMED, CAST, LOCKOUT.
  - IDLE: `arm`=1 → ARMED. Buttons are ignored.
  - ARMED: `stable` → CAST, latching the code (bit0→001, bit1→010, bit2→011). If the timeout counter reaches TIMEOUT_CYCLES-1 with no stable press → IDLE with `timeout` pulse. The timeout counter is cleared on entering ARMED.
  - CAST: lasts one cycle. `candidate` = latched code → LOCKOUT.
  - LOCKOUT: the lockout counter runs LOCKOUT_CYCLES, then waits until `sbtn`==0 → IDLE. A held button therefore can never cast twice.
- `arm` outside IDLE is ignored. It is not queued.
- If `stable` and timeout expiry coincide in ARMED, the cast wins and there is no `timeout` pulse.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

## Timing
- Reset (async assert, sync-released use): state IDLE, `candidate`=000, `ready`=0, `busy`=0, `timeout`=0, all counters and synchronizers 0. Reset mid-ballot discards the ballot with no pulse.
- All outputs are registered.
- `ready` rises the cycle after `arm` is sampled.
- Press latency: `candidate` is valid exactly 2+DEBOUNCE_CYCLES edges after the first edge sampling a clean one-hot `btn` in ARMED (6 at defaults).
- `candidate` is nonzero for exactly one cycle per ballot. `busy` is high from that cycle through the last LOCKOUT cycle.
- Minimum ballot-to-next-arm spacing is 1+LOCKOUT_CYCLES+1 cycles.

## Configuration
- `BALLOT_AUDIT_EN` defined: adds output `ballots_cast` [15:0] and `ballots_void` [15:0].
  - `ballots_cast` increments on each CAST and `ballots_void` on each `timeout`.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `voting_pkg`:
  - candidate code constants CAND_NONE=3'b000, CAND_1=3'b001, CAND_2=3'b010, CAND_3=3'b011 (shared with the tally block).
  - FSM state enum `ballot_state_t`.
- One sub-module: `btn_debounce` (synchronizer plus stability counter, outputs `stable` and the one-hot `sbtn`). The FSM and timers stay in `ballot_unit`.

## Test plan
- Reset, arm, hold `btn`=010 → `candidate`=3'b010 for one cycle, 6 cycles after first sampling (defaults). `busy` is high for 9 cycles. Next `arm` is accepted only after release.
- Arm, hold `btn`=011 for 20 cycles, then release → no cast. After 64 cycles, one `timeout` pulse and `ready`=0.
- Arm, press `btn`=001 bouncing (toggle every 2 cycles for 10 cycles, then steady) → exactly one `candidate`=001, timed from the steady edge.
- `btn`=100 held through CAST and LOCKOUT, then `arm` pulsed again while held → no second cast until released and re-pressed.
- Assert `rst_n`=0 one cycle before an expected cast → `candidate` stays 000 and state returns to IDLE. With `BALLOT_AUDIT_EN`, counters read 0.
- With `BALLOT_AUDIT_EN`: 3 casts and 2 timeouts → `ballots_cast`=3, `ballots_void`=2.
